exc_commit_ctrl: RTL

Exception/interrupt commit controller at the write-back end of the pipeline. It is the producer side of the CSR file's exception interface. It samples the CSR interrupt state, arbitrates interrupts against the WB instruction's exception flags, and drives the CSR exception-entry/ertn inputs. It also sequences the pipeline flush and the fetch redirect to EENTRY or ERA.

---
 rtl/exc_commit_ctrl_pkg.sv | 44 ++++
 rtl/exc_commit_ctrl_if.sv | 44 ++++
 rtl/exc_commit_ctrl_prio_enc.sv | 38 +++
 rtl/exc_commit_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/exc_commit_ctrl_pkg.sv
// Shared constants and types for the exception/interrupt commit controller.
package exc_commit_ctrl_pkg;

  // ecode values driven to the CSR file
  localparam int unsigned ECODE_INT  = 32'h00;
  localparam int unsigned ECODE_ADEF = 32'h08;
  localparam int unsigned ECODE_ALE  = 32'h09;
  localparam int unsigned ECODE_SYS  = 32'h0B;
  localparam int unsigned ECODE_BRK  = 32'h0C;
  localparam int unsigned ECODE_INE  = 32'h0D;

  // every exception committed here uses esubcode 0
  localparam int unsigned ESUB_ZERO  = 32'h0;

  // bit positions inside wb_exc
  localparam int unsigned EXC_ALE  = 0;
  localparam int unsigned EXC_BRK  = 1;
  localparam int unsigned EXC_SYS  = 2;
  localparam int unsigned EXC_INE  = 3;
  localparam int unsigned EXC_ADEF = 4;

  // interrupt line layout in ECFG.LIE / ESTAT.IS
  localparam int unsigned NUM_INT       = 13;
  localparam int unsigned INT_BIT_RSVD  = 10;
  localparam int unsigned INT_BIT_TIMER = 11;
  localparam logic [NUM_INT-1:0] INT_MASK = ~(13'(1) << INT_BIT_RSVD);

  // flush counter width, enough for FLUSH_CYCLES up to 15
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  // which address is reported into BADV
  typedef enum logic [1:0] {
    VADDR_NONE = 2'd0,
    VADDR_PC   = 2'd1,
    VADDR_DATA = 2'd2
  } vaddr_sel_t;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// WB/CSR/fetch signal bundle around the commit controller.
// master = the controller, slave = pipeline/CSR/fetch side.
interface exc_commit_ctrl_if #(
  parameter int ECODE_W = 6,
  parameter int ESUB_W  = 9
);
  logic               wb_valid;
  logic [31:0]        wb_pc;
  logic [31:0]        wb_vaddr;
  logic [4:0]         wb_exc;
  logic               wb_ertn;
  logic               csr_crmd_ie;
  logic [12:0]        csr_ecfg_lie;
  logic [12:0]        csr_estat_is;
  logic [31:0]        csr_eentry;
  logic [31:0]        csr_era;
  logic               csr_wb_ex;
  logic [ECODE_W-1:0] csr_wb_ecode;
  logic [ESUB_W-1:0]  csr_wb_esubcode;
  logic [31:0]        csr_wb_pc;
  logic [31:0]        csr_wb_vaddr;
  logic               csr_ertn_flush;
  logic               pipe_flush;
  logic               int_pending;
  logic               redir_valid;
  logic [31:0]        redir_pc;
  logic               redir_ready;

  modport master (
    input  wb_valid, wb_pc, wb_vaddr, wb_exc, wb_ertn,
    input  csr_crmd_ie, csr_ecfg_lie, csr_estat_is, csr_eentry, csr_era,
    input  redir_ready,
    output csr_wb_ex, csr_wb_ecode, csr_wb_esubcode, csr_wb_pc, csr_wb_vaddr,
    output csr_ertn_flush, pipe_flush, int_pending, redir_valid, redir_pc
  );

  modport slave (
    output wb_valid, wb_pc, wb_vaddr, wb_exc, wb_ertn,
    output csr_crmd_ie, csr_ecfg_lie, csr_estat_is, csr_eentry, csr_era,
    output redir_ready,
    input  csr_wb_ex, csr_wb_ecode, csr_wb_esubcode, csr_wb_pc, csr_wb_vaddr,
    input  csr_ertn_flush, pipe_flush, int_pending, redir_valid, redir_pc
  );
endinterface

// File: rtl/exc_commit_ctrl_prio_enc.sv
// exc_prio_enc: fixed-priority encoder from pending interrupt + WB exception
// flags to the ecode/esubcode pair and the BADV source select.
module exc_commit_ctrl_prio_enc
  import exc_commit_ctrl_pkg::*;
#(
  parameter int ECODE_W = 6,
  parameter int ESUB_W  = 9
) (
  input  logic               int_hit,
  input  logic [4:0]         exc,
  output logic [ECODE_W-1:0] ecode,
  output logic [ESUB_W-1:0]  esubcode,
  output vaddr_sel_t         sel_vaddr
);

  // interrupt > adef > ine > sys > brk > ale
  always_comb begin
    ecode     = ECODE_W'(ECODE_INT);
    esubcode  = ESUB_W'(ESUB_ZERO);
    sel_vaddr = VADDR_NONE;
    if (int_hit) begin
      ecode = ECODE_W'(ECODE_INT);
    end else if (exc[EXC_ADEF]) begin
      ecode     = ECODE_W'(ECODE_ADEF);
      sel_vaddr = VADDR_PC;
    end else if (exc[EXC_INE]) begin
      ecode = ECODE_W'(ECODE_INE);
    end else if (exc[EXC_SYS]) begin
      ecode = ECODE_W'(ECODE_SYS);
    end else if (exc[EXC_BRK]) begin
      ecode = ECODE_W'(ECODE_BRK);
    end else if (exc[EXC_ALE]) begin
      ecode     = ECODE_W'(ECODE_ALE);
      sel_vaddr = VADDR_DATA;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit controller at the end of write-back.
// Arbitrates a registered interrupt request against the WB instruction's
// exception flags and ertn, pulses the CSR entry/ertn inputs, holds the
// pipeline flush and then offers a redirect to EENTRY or ERA.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | watch WB, commit exception/ertn with a one-cycle CSR pulse
//   ST_FLUSH | pipe_flush held while the flush counter runs down
//   ST_REDIR | pipe_flush + redir_valid until fetch takes the redirect
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int ECODE_W      = 6,
  parameter int ESUB_W       = 9
) (
  input logic                  clk,
  input logic                  reset,
  exc_commit_ctrl_if.master    bus
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   flush_cnt;
  logic               int_req;
  logic               int_pending_q;
  logic [31:0]        redir_pc_q;
  logic               take_exc;
  logic               commit;
  logic [ECODE_W-1:0] enc_ecode;
  logic [ESUB_W-1:0]  enc_esub;
  vaddr_sel_t         enc_sel;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  // reserved line 10 never raises an interrupt
  assign int_req  = bus.csr_crmd_ie & |(bus.csr_ecfg_lie & bus.csr_estat_is & INT_MASK);
  assign take_exc = int_pending_q | (|bus.wb_exc);
  // reset gates commit so a reset cycle can never emit a CSR pulse
  assign commit   = (state == ST_IDLE) & ~reset & bus.wb_valid &
                    (take_exc | bus.wb_ertn);

  exc_commit_ctrl_prio_enc #(
    .ECODE_W (ECODE_W),
    .ESUB_W  (ESUB_W)
  ) u_prio_enc (
    .int_hit   (int_pending_q),
    .exc       (bus.wb_exc),
    .ecode     (enc_ecode),
    .esubcode  (enc_esub),
    .sel_vaddr (enc_sel)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (commit)                state_nxt = ST_FLUSH;
      ST_FLUSH: if (flush_cnt == '0)       state_nxt = ST_REDIR;
      ST_REDIR: if (bus.redir_ready)       state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  // interrupt sampling, flush counter and latched redirect target
  always_ff @(posedge clk) begin
    if (reset) begin
      int_pending_q <= 1'b0;
      flush_cnt     <= '0;
      redir_pc_q    <= '0;
    end else begin
      int_pending_q <= int_req;
      if (commit) begin
        flush_cnt  <= CNT_LOAD;
        redir_pc_q <= take_exc ? bus.csr_eentry : bus.csr_era;
      end else if (state == ST_FLUSH && flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 1'b1;
      end
    end
  end

  // outputs: CSR pulses only on the IDLE commit cycle
  always_comb begin
    bus.csr_wb_ex       = 1'b0;
    bus.csr_wb_ecode    = '0;
    bus.csr_wb_esubcode = '0;
    bus.csr_wb_pc       = '0;
    bus.csr_wb_vaddr    = '0;
    bus.csr_ertn_flush  = 1'b0;
    bus.pipe_flush      = 1'b0;
    bus.redir_valid     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (commit && take_exc) begin
          bus.csr_wb_ex       = 1'b1;
          bus.csr_wb_ecode    = enc_ecode;
          bus.csr_wb_esubcode = enc_esub;
          bus.csr_wb_pc       = bus.wb_pc;
          case (enc_sel)
            VADDR_PC:   bus.csr_wb_vaddr = bus.wb_pc;
            VADDR_DATA: bus.csr_wb_vaddr = bus.wb_vaddr;
            default:    bus.csr_wb_vaddr = '0;
          endcase
          bus.pipe_flush = 1'b1;
        end else if (commit) begin
          bus.csr_ertn_flush = 1'b1;
          bus.pipe_flush     = 1'b1;
        end
      end
      ST_FLUSH: bus.pipe_flush = 1'b1;
      ST_REDIR: begin
        bus.pipe_flush  = 1'b1;
        bus.redir_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.int_pending = int_pending_q;
  assign bus.redir_pc    = redir_pc_q;

endmodule
